serial_ripple_subtractor: RTL and testbench

//   Bit-serial ripple-borrow subtractor, the inverse companion of the 4-bit ripple-carry adder.

---
 rtl/serial_ripple_subtractor.sv | 119 +++++++++++
 tb/tb_serial_ripple_subtractor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - borrow_in, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow and a start/busy/done handshake.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-2:0] res_r;
    logic             bw_r;
    logic [CNT_W-1:0] cnt_r;

    logic             a_bit_s;
    logic             b_bit_s;
    logic             d_bit_s;
    logic             bw_next_s;
    logic [WIDTH-1:0] res_s;

    function automatic logic fs_diff(input logic x, input logic y, input logic bw);
        return x ^ y ^ bw;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bw);
        return (~x & y) | (~(x ^ y) & bw);
    endfunction

    // Full-subtractor cell on the currently selected operand bit pair.
    always_comb begin
        a_bit_s   = a_r[cnt_r];
        b_bit_s   = b_r[cnt_r];
        d_bit_s   = fs_diff(a_bit_s, b_bit_s, bw_r);
        bw_next_s = fs_borrow(a_bit_s, b_bit_s, bw_r);
        // New bit enters at the top; after the MSB step the whole result is aligned.
        res_s     = {d_bit_s, res_r};
    end

    // Handshake FSM, operand/borrow latches, result shifter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            res_r      <= '0;
            bw_r       <= 1'b0;
            cnt_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        bw_r    <= borrow_in;
                        res_r   <= '0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                SHIFT: begin
                    res_r <= res_s[WIDTH-1:1];
                    bw_r  <= bw_next_s;
                    if (cnt_r == LAST_IDX) begin
                        cnt_r      <= '0;
                        diff       <= res_s;
                        borrow_out <= bw_next_s;
                        // Signed overflow only when operand signs differ and the sign flips.
                        overflow   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (d_bit_s ^ a_r[WIDTH-1]);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state_r    <= DONE_ST;
                    end else begin
                        cnt_r      <= cnt_r + CNT_W'(1);
                    end
                end
                DONE_ST: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench: a 4-bit and an 8-bit instance checked every cycle against an
// arithmetic reference model, plus directed vectors with hand-computed results.
module tb_serial_ripple_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start_v  [2];
    logic [7:0] a_v      [2];
    logic [7:0] b_v      [2];
    logic       bin_v    [2];

    logic       busy4, done4, bo4, ov4;
    logic [3:0] diff4;
    logic       busy8, done8, bo8, ov8;
    logic [7:0] diff8;

    logic       busy_v [2];
    logic       done_v [2];
    logic [7:0] diff_v [2];
    logic       bo_v   [2];
    logic       ov_v   [2];

    int checks = 0;
    int errors = 0;

    serial_ripple_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_v[0][3:0]), .b(b_v[0][3:0]), .borrow_in(bin_v[0]),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4), .overflow(ov4)
    );

    serial_ripple_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_v[1]), .b(b_v[1]), .borrow_in(bin_v[1]),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
    );

    assign busy_v[0] = busy4;  assign busy_v[1] = busy8;
    assign done_v[0] = done4;  assign done_v[1] = done8;
    assign diff_v[0] = {4'b0000, diff4};  assign diff_v[1] = diff8;
    assign bo_v[0]   = bo4;    assign bo_v[1]   = bo8;
    assign ov_v[0]   = ov4;    assign ov_v[1]   = ov8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int width_of(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    // Reference arithmetic: unsigned and signed views of a - b - bin at width w.
    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } res_t;

    function automatic res_t calc(input int w, input int a, input int b, input int bin);
        res_t r;
        int   full;
        int   sa;
        int   sb;
        int   sr;
        full = 1 << w;
        r.d  = 8'((a - b - bin + 2 * full) % full);
        r.bo = (a < b + bin);
        sa   = (a >= full / 2) ? a - full : a;
        sb   = (b >= full / 2) ? b - full : b;
        sr   = sa - sb - bin;
        r.ov = (sr < -(full / 2)) || (sr > full / 2 - 1);
        return r;
    endfunction

    // Model state: ops in flight counted down in cycles, results released on done.
    int   m_rem    [2];
    logic m_indone [2];
    res_t m_pend   [2];
    logic e_busy   [2];
    logic e_done   [2];
    res_t e_res    [2];
    logic m_valid = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_rem[d]    <= 0;
                m_indone[d] <= 1'b0;
                e_busy[d]   <= 1'b0;
                e_done[d]   <= 1'b0;
                e_res[d]    <= '0;
            end else if (m_indone[d]) begin
                m_indone[d] <= 1'b0;
                e_done[d]   <= 1'b0;
            end else if (m_rem[d] == 0) begin
                if (start_v[d]) begin
                    m_pend[d] <= calc(width_of(d), int'(a_v[d]) & ((1 << width_of(d)) - 1),
                                      int'(b_v[d]) & ((1 << width_of(d)) - 1), int'(bin_v[d]));
                    m_rem[d]  <= width_of(d);
                    e_busy[d] <= 1'b1;
                end
            end else begin
                m_rem[d] <= m_rem[d] - 1;
                if (m_rem[d] == 1) begin
                    e_done[d]   <= 1'b1;
                    e_busy[d]   <= 1'b0;
                    e_res[d]    <= m_pend[d];
                    m_indone[d] <= 1'b1;
                end
            end
        end
        if (!rst_n) m_valid <= 1'b1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("w%0d_busy", width_of(d)), 32'(busy_v[d]), 32'(e_busy[d]));
                check($sformatf("w%0d_done", width_of(d)), 32'(done_v[d]), 32'(e_done[d]));
                check($sformatf("w%0d_diff", width_of(d)), 32'(diff_v[d]), 32'(e_res[d].d));
                check($sformatf("w%0d_borrow", width_of(d)), 32'(bo_v[d]), 32'(e_res[d].bo));
                check($sformatf("w%0d_ovf", width_of(d)), 32'(ov_v[d]), 32'(e_res[d].ov));
            end
        end
    end

    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b, input logic bin);
        a_v[d]     = a;
        b_v[d]     = b;
        bin_v[d]   = bin;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int n);
        n = 0;
        while (!done_v[d] && n < 30) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("w%0d_done_seen", width_of(d)), 32'(done_v[d]), 32'd1);
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; a_v[d] = 8'd0; b_v[d] = 8'd0; bin_v[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_diff", 32'(diff4), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 4 - 8
        issue(0, 8'd4, 8'd8, 1'b0);
        wait_done(0, n);
        check("t1_latency", 32'(n), 32'd4);
        check("t1_diff", 32'(diff4), 32'h0000000c);
        check("t1_borrow", 32'(bo4), 32'd1);
        check("t1_ovf", 32'(ov4), 32'd1);
        @(negedge clk);

        // 2: 8 - 5
        issue(0, 8'd8, 8'd5, 1'b0);
        wait_done(0, n);
        check("t2_diff", 32'(diff4), 32'd3);
        check("t2_borrow", 32'(bo4), 32'd0);
        check("t2_ovf", 32'(ov4), 32'd1);
        @(negedge clk);

        // 3: 0 - 0 - 1, then start raised in the done cycle and held into IDLE
        issue(0, 8'd0, 8'd0, 1'b1);
        wait_done(0, n);
        check("t3_diff", 32'(diff4), 32'h0000000f);
        check("t3_borrow", 32'(bo4), 32'd1);
        check("t3_ovf", 32'(ov4), 32'd0);
        a_v[0] = 8'd5; b_v[0] = 8'd5; bin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, n);
        check("t3b_latency", 32'(n), 32'd4);
        check("t3b_diff", 32'(diff4), 32'd0);
        check("t3b_borrow", 32'(bo4), 32'd0);
        @(negedge clk);

        // 4: start and operand changes while busy are ignored
        issue(0, 8'd9, 8'd3, 1'b0);
        @(negedge clk);
        a_v[0] = 8'd1; b_v[0] = 8'd1; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, n);
        check("t4_diff", 32'(diff4), 32'd6);
        check("t4_borrow", 32'(bo4), 32'd0);
        repeat (3) @(negedge clk);

        // 5: reset mid-op aborts; then a clean op
        issue(0, 8'd7, 8'd2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(busy4), 32'd0);
        check("t5_done", 32'(done4), 32'd0);
        check("t5_diff", 32'(diff4), 32'd0);
        check("t5_borrow", 32'(bo4), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        issue(0, 8'd7, 8'd2, 1'b0);
        wait_done(0, n);
        check("t5b_diff", 32'(diff4), 32'd5);
        check("t5b_ovf", 32'(ov4), 32'd0);
        @(negedge clk);

        // start held high re-triggers on every IDLE cycle
        a_v[0] = 8'd3; b_v[0] = 8'd5; bin_v[0] = 1'b0; start_v[0] = 1'b1;
        repeat (12) @(negedge clk);
        start_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("held_diff", 32'(diff4), 32'h0000000e);

        // 6: 8-bit instance
        issue(1, 8'd200, 8'd55, 1'b0);
        wait_done(1, n);
        check("t6_latency", 32'(n), 32'd8);
        check("t6_diff", 32'(diff8), 32'd145);
        check("t6_borrow", 32'(bo8), 32'd0);
        check("t6_ovf", 32'(ov8), 32'd0);
        @(negedge clk);
        issue(1, 8'd0, 8'd1, 1'b0);
        wait_done(1, n);
        check("t6b_diff", 32'(diff8), 32'd255);
        check("t6b_borrow", 32'(bo8), 32'd1);
        check("t6b_ovf", 32'(ov8), 32'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
